// File: rtl/bf_out_xbar_pkg.sv
// ============================================================================
// Module  : bf_out_xbar_pkg
// Brief   : Shared mode encodings, default delays and helpers for the
//           butterfly output crossbar.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bf_out_xbar_pkg;

  // Mode encoding shared with the butterfly controller
  localparam logic [2:0] MODE_BYPASS = 3'b000;

  // Default select latencies for short-pipe and long-pipe modes
  localparam int DLY_SHORT_DEF = 4;
  localparam int DLY_LONG_DEF  = 7;

  // Width of one lane select for a given number of butterfly units
  function automatic int sel_width(input int num_bf);
    return (num_bf < 1) ? 1 : $clog2(2 * num_bf);
  endfunction

  // Short-pipe modes have both upper mode bits set
  function automatic logic is_short_mode(input logic [2:0] mode);
    return mode[2] & mode[1];
  endfunction

  // Bypass mode routes the live inputs without delay
  function automatic logic is_bypass_mode(input logic [2:0] mode);
    return (mode == MODE_BYPASS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bf_out_xbar_lane_sel.sv
// ============================================================================
// Module  : bf_lane_sel
// Brief   : One output lane of the crossbar. Select k picks bf_lower[k/2]
//           for even k and bf_upper[k/2] for odd k; a select beyond the
//           last source drives zero and raises oor_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_lane_sel
  import bf_out_xbar_pkg::*;
#(
  parameter int NUM_BF = 2,
  parameter int DATA_W = 23,
  parameter int SEL_W  = sel_width(NUM_BF)
) (
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_BF*DATA_W-1:0] bf_upper_i,
  input  logic [NUM_BF*DATA_W-1:0] bf_lower_i,
  output logic [DATA_W-1:0]        lane_o,
  output logic                     oor_o
);

  // Compare the select against every source index; no match means out of range
  always_comb begin
    lane_o = '0;
    oor_o  = 1'b1;
    for (int j = 0; j < NUM_BF; j++) begin
      if (sel_i == SEL_W'(2 * j)) begin
        lane_o = bf_lower_i[j*DATA_W +: DATA_W];
        oor_o  = 1'b0;
      end
      if (sel_i == SEL_W'(2 * j + 1)) begin
        lane_o = bf_upper_i[j*DATA_W +: DATA_W];
        oor_o  = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bf_out_xbar.sv
// ============================================================================
// Module  : bf_out_xbar
// Brief   : Output crossbar after the butterfly array. Lane selects and the
//           write address travel through a tappable delay line so they meet
//           the butterfly results; outputs are registered and tagged.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_out_xbar
  import bf_out_xbar_pkg::*;
#(
  parameter int DATA_W    = 23,
  parameter int NUM_BF    = 2,
  parameter int SEL_W     = sel_width(NUM_BF),
  parameter int ADDR_W    = 6,
  parameter int DLY_SHORT = DLY_SHORT_DEF,
  parameter int DLY_LONG  = DLY_LONG_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 mode_i,
  input  logic                       in_valid_i,
  input  logic [2*NUM_BF*SEL_W-1:0]  sel_in_i,
  input  logic [ADDR_W-1:0]          addr_in_i,
  input  logic [NUM_BF*DATA_W-1:0]   bf_upper_i,
  input  logic [NUM_BF*DATA_W-1:0]   bf_lower_i,
  output logic [2*NUM_BF*DATA_W-1:0] d_out_o,
  output logic                       out_valid_o,
  output logic [ADDR_W-1:0]          addr_out_o,
  output logic                       busy_o,
  output logic [1:0]                 err_o
);

  localparam int L     = 2 * NUM_BF;
  localparam int TAP_W = $clog2(DLY_LONG + 1);

  // Delay line: stage s holds the entry issued s+1 cycles ago
  logic              stg_valid_q [DLY_LONG];
  logic [ADDR_W-1:0] stg_addr_q  [DLY_LONG];
  logic [L*SEL_W-1:0] stg_sel_q  [DLY_LONG];

  logic [2:0]         mode_q;
  logic [1:0]         err_q;
  logic [1:0]         err_d;
  logic               busy;
  logic [2:0]         dec_mode;
  logic [TAP_W-1:0]   tap;
  logic               tap_valid;
  logic [ADDR_W-1:0]  tap_addr;
  logic [L*SEL_W-1:0] tap_sel;
  logic [L*DATA_W-1:0] lanes_d;
  logic [L-1:0]       lane_oor;
  logic [L*DATA_W-1:0] d_out_q;
  logic [ADDR_W-1:0]  addr_out_q;
  logic               out_valid_q;

  // Free-running shift of {valid, addr, sel}; reset discards all in-flight entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DLY_LONG; s++) begin
        stg_valid_q[s] <= 1'b0;
        stg_addr_q[s]  <= '0;
        stg_sel_q[s]   <= '0;
      end
    end else begin
      stg_valid_q[0] <= in_valid_i;
      stg_addr_q[0]  <= addr_in_i;
      stg_sel_q[0]   <= sel_in_i;
      for (int s = 1; s < DLY_LONG; s++) begin
        stg_valid_q[s] <= stg_valid_q[s-1];
        stg_addr_q[s]  <= stg_addr_q[s-1];
        stg_sel_q[s]   <= stg_sel_q[s-1];
      end
    end
  end

  // Busy while any stage still carries a valid entry
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < DLY_LONG; s++) begin
      busy = busy | stg_valid_q[s];
    end
  end

  // Tap depth; an idle line lets a new issue use its own mode immediately
  always_comb begin
    dec_mode = (in_valid_i && !busy) ? mode_i : mode_q;
    if (is_bypass_mode(dec_mode)) begin
      tap = '0;
    end else if (is_short_mode(dec_mode)) begin
      tap = TAP_W'(DLY_SHORT);
    end else begin
      tap = TAP_W'(DLY_LONG);
    end
  end

  // Pick the entry whose butterfly data is on the inputs this cycle
  always_comb begin
    tap_valid = in_valid_i;
    tap_addr  = addr_in_i;
    tap_sel   = sel_in_i;
    for (int s = 0; s < DLY_LONG; s++) begin
      if (tap == TAP_W'(s + 1)) begin
        tap_valid = stg_valid_q[s];
        tap_addr  = stg_addr_q[s];
        tap_sel   = stg_sel_q[s];
      end
    end
  end

  generate
    for (genvar i = 0; i < L; i++) begin : g_lane
      bf_lane_sel #(
        .NUM_BF (NUM_BF),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
      ) u_lane_sel (
        .sel_i      (tap_sel[i*SEL_W +: SEL_W]),
        .bf_upper_i (bf_upper_i),
        .bf_lower_i (bf_lower_i),
        .lane_o     (lanes_d[i*DATA_W +: DATA_W]),
        .oor_o      (lane_oor[i])
      );
    end
  endgenerate

  // Output register; data and address hold when no valid entry is tapped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      addr_out_q  <= '0;
    end else begin
      out_valid_q <= tap_valid;
      if (tap_valid) begin
        d_out_q    <= lanes_d;
        addr_out_q <= tap_addr;
      end
    end
  end

  // Sticky error sources: bad select on a valid entry, mode change mid-flight
  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (tap_valid & (|lane_oor));
    err_d[1] = err_q[1] | (in_valid_i & busy & (mode_i != mode_q));
  end

  // Mode only follows the input while the line is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_BYPASS;
      err_q  <= '0;
    end else begin
      err_q <= err_d;
      if (!busy) begin
        mode_q <= mode_i;
      end
    end
  end

  assign d_out_o     = d_out_q;
  assign out_valid_o = out_valid_q;
  assign addr_out_o  = addr_out_q;
  assign busy_o      = busy;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bf_out_xbar.sv
// ============================================================================
// Module  : tb_bf_out_xbar
// Brief   : Self-checking bench for bf_out_xbar (NUM_BF=2 main instance,
//           NUM_BF=3 instance for out-of-range selects).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bf_out_xbar;

  localparam int DW = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NUM_BF=2 instance
  logic [2:0]  mode;
  logic        in_valid;
  logic [7:0]  sel_in;
  logic [5:0]  addr_in;
  logic [45:0] bf_upper, bf_lower;
  logic [91:0] d_out;
  logic        out_valid;
  logic [5:0]  addr_out;
  logic        busy;
  logic [1:0]  err;

  // NUM_BF=3 instance
  logic [2:0]   mode3;
  logic         in_valid3;
  logic [17:0]  sel3;
  logic [5:0]   addr3;
  logic [68:0]  bfu3, bfl3;
  logic [137:0] d_out3;
  logic         ov3;
  logic [5:0]   ao3;
  logic         busy3;
  logic [1:0]   err3;

  bf_out_xbar #(.NUM_BF(2)) dut (
    .clk(clk), .rst(rst), .mode_i(mode), .in_valid_i(in_valid),
    .sel_in_i(sel_in), .addr_in_i(addr_in), .bf_upper_i(bf_upper),
    .bf_lower_i(bf_lower), .d_out_o(d_out), .out_valid_o(out_valid),
    .addr_out_o(addr_out), .busy_o(busy), .err_o(err)
  );

  bf_out_xbar #(.NUM_BF(3)) dut3 (
    .clk(clk), .rst(rst), .mode_i(mode3), .in_valid_i(in_valid3),
    .sel_in_i(sel3), .addr_in_i(addr3), .bf_upper_i(bfu3),
    .bf_lower_i(bfl3), .d_out_o(d_out3), .out_valid_o(ov3),
    .addr_out_o(ao3), .busy_o(busy3), .err_o(err3)
  );

  typedef struct {
    int          due;
    logic [5:0]  addr;
    logic [91:0] lanes;
  } exp_t;

  typedef struct {
    logic [7:0]  sel;
    logic [5:0]  addr;
    logic [22:0] lo0, up0, lo1, up1;
    logic [91:0] exp;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[4];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ov_seen  = 0;
  int   ov0;

  function automatic logic [22:0] dat(input int c, input int k);
    return 23'(c * 16 + k + 1);
  endfunction

  // Expected lanes when data of cycle c is on the butterfly inputs
  function automatic logic [91:0] model(input logic [7:0] s, input int c);
    logic [91:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*DW +: DW] = dat(c, int'(s[i*2 +: 2]));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare outputs against the scoreboard, then drive defaults
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      ov_seen++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got addr %0h expected no output (cycle %0d)", addr_out, cyc);
      end else begin
        e = sbq.pop_front();
        chk("out_cycle", 192'(cyc), 192'(e.due));
        chk("out_addr", 192'(addr_out), 192'(e.addr));
        chk("out_lanes", 192'(d_out), 192'(e.lanes));
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_out_valid: got out_valid=0 expected addr %0h (cycle %0d)", e.addr, cyc);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bf_lower[j*DW +: DW] = dat(cyc, 2 * j);
      bf_upper[j*DW +: DW] = dat(cyc, 2 * j + 1);
    end
  endtask

  task automatic issue(input logic [2:0] m, input logic [5:0] a, input logic [7:0] s, input int t);
    exp_t e;
    mode     = m;
    in_valid = 1'b1;
    addr_in  = a;
    sel_in   = s;
    e.due    = cyc + t + 1;
    e.addr   = a;
    e.lanes  = model(s, cyc + t);
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) step();
    chk("idle_busy", 192'(busy), 192'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    vt[0] = '{8'b11100100, 6'd1, 23'd1, 23'd2, 23'd3, 23'd4,
              {23'd4, 23'd3, 23'd2, 23'd1}};
    vt[1] = '{8'b00011011, 6'd2, 23'd5, 23'd6, 23'd7, 23'd8,
              {23'd5, 23'd6, 23'd7, 23'd8}};
    vt[2] = '{8'b10101010, 6'd3, 23'd9, 23'd10, 23'd11, 23'd12,
              {23'd11, 23'd11, 23'd11, 23'd11}};
    vt[3] = '{8'b00110101, 6'd4, 23'd13, 23'd14, 23'd15, 23'd16,
              {23'd13, 23'd16, 23'd14, 23'd14}};

    rst = 1'b1; mode = 3'b000; in_valid = 1'b0; sel_in = '0; addr_in = '0;
    bf_upper = '0; bf_lower = '0;
    mode3 = 3'b000; in_valid3 = 1'b0; sel3 = '0; addr3 = '0; bfu3 = '0; bfl3 = '0;
    repeat (3) step();
    chk("rst_out_valid", 192'(out_valid), 192'(0));
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_err", 192'(err), 192'(0));
    chk("rst_dout", 192'(d_out), 192'(0));
    chk("rst_addr", 192'(addr_out), 192'(0));
    rst = 1'b0;
    step();

    // Bypass table: one-cycle latency, back to back
    for (int v = 0; v < 4; v++) begin
      mode = 3'b000; in_valid = 1'b1; sel_in = vt[v].sel; addr_in = vt[v].addr;
      bf_lower = {vt[v].lo1, vt[v].lo0};
      bf_upper = {vt[v].up1, vt[v].up0};
      sbq.push_back('{cyc + 1, vt[v].addr, vt[v].exp});
      step();
    end
    wait_idle();

    // Short mode: butterfly data arrives 4 cycles after issue
    mode = 3'b110; in_valid = 1'b1; addr_in = 6'd5; sel_in = 8'b00011011;
    sbq.push_back('{cyc + 5, 6'd5, {23'd1, 23'd2, 23'd3, 23'd4}});
    repeat (4) step();
    bf_lower = {23'd3, 23'd1};
    bf_upper = {23'd4, 23'd2};
    step();
    step();
    chk("hold_out_valid", 192'(out_valid), 192'(0));
    chk("hold_dout", 192'(d_out), 192'({23'd1, 23'd2, 23'd3, 23'd4}));
    chk("hold_addr", 192'(addr_out), 192'(5));
    wait_idle();

    // Long mode burst of 10
    ov0 = ov_seen;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++) s[i*2 +: 2] = 2'((i + t) % 4);
      issue(3'b001, 6'(t), s, 7);
      step();
    end
    wait_idle();
    chk("burst_count", 192'(ov_seen - ov0), 192'(10));
    chk("burst_drained", 192'(sbq.size()), 192'(0));
    chk("err_clean", 192'(err), 192'(0));

    // Mode change while busy: second issue keeps the long latency
    issue(3'b001, 6'd20, 8'b11100100, 7);
    step();
    issue(3'b110, 6'd21, 8'b00011011, 7);
    step();
    chk("err_mode_change", 192'(err), 192'(2'b10));
    wait_idle();
    issue(3'b110, 6'd22, 8'b11100100, 4);
    step();
    wait_idle();
    chk("short_drained", 192'(sbq.size()), 192'(0));
    chk("err_sticky", 192'(err), 192'(2'b10));

    // Out-of-range select on the 3-butterfly instance
    chk("oor_err_before", 192'(err3), 192'(0));
    sel3 = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    bfl3 = {23'd14, 23'd12, 23'd10};
    bfu3 = {23'd15, 23'd13, 23'd11};
    addr3 = 6'd9; in_valid3 = 1'b1;
    step();
    in_valid3 = 1'b0;
    chk("oor_valid", 192'(ov3), 192'(1));
    chk("oor_lanes", 192'(d_out3), 192'({23'd14, 23'd13, 23'd12, 23'd11, 23'd10, 23'd0}));
    chk("oor_err", 192'(err3), 192'(2'b01));

    // Reset in the middle of a long burst
    for (int t = 0; t < 3; t++) begin
      issue(3'b001, 6'(30 + t), 8'b11100100, 7);
      step();
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", 192'(busy), 192'(0));
    chk("midrst_out_valid", 192'(out_valid), 192'(0));
    chk("midrst_dout", 192'(d_out), 192'(0));
    chk("midrst_err", 192'(err), 192'(0));
    sbq.delete();
    step();
    rst = 1'b0;
    ov0 = ov_seen;
    repeat (10) step();
    chk("post_rst_quiet", 192'(ov_seen - ov0), 192'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bf_out_xbar.md
Name: bf_out_xbar

Overview:
- Parametrised output crossbar placed after the butterfly array of the Dilithium NTT/INTT datapath.
- Routes the upper/lower results of NUM_BF butterflies onto 2*NUM_BF memory write lanes.
- Lane selects and the write address are issued with the butterfly operands. They are carried through an internal mode-dependent delay line so they arrive together with the butterfly results.
- Adds beyond the 2-butterfly fixed network: registered outputs, valid/address tagging, a mode-change interlock and select-error detection.

Parameters:
- DATA_W, 23, coefficient width.
- NUM_BF, 2, butterfly units; lanes L = 2*NUM_BF.
- SEL_W, $clog2(2*NUM_BF), per-lane select width.
- ADDR_W, 6, write address tag width.
- DLY_SHORT, 4, select latency for short-pipe modes.
- DLY_LONG, 7, select latency for long-pipe modes; must satisfy DLY_LONG >= DLY_SHORT >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  3  operation mode; same encoding as the butterfly controller.
- in_valid  in  1  selects and address are issued this cycle.
- sel_in  in  L*SEL_W  lane selects; lane i occupies bits [i*SEL_W +: SEL_W].
- addr_in  in  ADDR_W  write address tag.
- bf_upper  in  NUM_BF*DATA_W  butterfly upper outputs; unit j at [j*DATA_W +: DATA_W].
- bf_lower  in  NUM_BF*DATA_W  butterfly lower outputs, same packing.
- d_out  out  L*DATA_W  routed lanes, registered.
- out_valid  out  1  d_out and addr_out are valid.
- addr_out  out  ADDR_W  delayed address tag.
- busy  out  1  delay line holds at least one valid entry.
- err  out  2  sticky flags: bit0 = select out of range, bit1 = mode change while busy.

Behaviour:

Mode register mode_q:
- Loads mode at a clock edge only when busy=0.
- Otherwise mode_q holds.

Tap depth T, decoded from mode_q:
- mode_q==3'b000 -> T=0 (bypass).
- mode_q[2]&mode_q[1] -> T=DLY_SHORT.
- Any other mode -> T=DLY_LONG.
- In the in_valid cycle, when busy=0, T decodes from the incoming mode. This lets a transaction launched in a new mode use its own depth.

Delay line:
- Free-running shift register, DLY_LONG stages deep.
- Each stage holds {valid, addr, sel}.
- Stage 0 captures {in_valid, addr_in, sel_in} every cycle.
- No stall and no backpressure.

Tapped entry:
- T=0: the live inputs.
- Otherwise: stage T-1, i.e. the entry issued T cycles earlier.
- The butterfly data present on bf_upper/bf_lower in that cycle belongs to the tapped entry.

Lane mux for lane i with k = tapped sel_i:
- k even -> bf_lower[k/2].
- k odd -> bf_upper[k/2].
- k >= L (possible only when L is not a power of two) -> lane i outputs 0, and err[0] sets if the tapped valid=1.

Output register:
- On each clk: d_out <= muxed lanes, addr_out <= tapped addr, out_valid <= tapped valid.
- Total select-to-output latency is T+1 cycles.
- When tapped valid=0, d_out and addr_out hold their previous values.

busy:
- Combinational OR of the valid bits in stages 0..DLY_LONG-1.

err[1]:
- Sets when in_valid=1 && busy=1 && mode != mode_q.
- The transaction is still processed under mode_q.

Error flags:
- Sticky; cleared only by rst.

Back-to-back:
- One transaction per cycle is sustained indefinitely within a single mode.

Reset:
- Asynchronous and active-high.
- All valid bits, mode_q, d_out, addr_out, out_valid and err go to 0.
- Reset asserted mid-operation discards every in-flight entry; no output is produced for them after release.

Decomposition:
- Shared package: mode encodings (MODE_BYPASS=3'b000 and the short/long decode), default DLY_SHORT/DLY_LONG, and a function computing SEL_W.
- Sub-module: a lane mux, bf_lane_sel (parametrised NUM_BF, DATA_W; purely combinational), instantiated L times.
- The existing generic delay module is not reused. The tap must be selectable, so the delay line is implemented locally as the sole sequential core.

Test Plan:
1. Reset with NUM_BF=2, mode=3'b000, in_valid=1, sel_in={2'b11,2'b10,2'b01,2'b00}, bf_lower0=1, bf_upper0=2, bf_lower1=3, bf_upper1=4 -> after 1 cycle: out_valid=1, lanes0..3 = 1,2,3,4.
2. mode=3'b110, issue addr 5 with selects reversed; bf inputs are driven 4 cycles later -> out_valid=1 with addr_out=5 exactly 5 cycles after issue, lanes = 4,3,2,1.
3. mode=3'b001, 10 back-to-back issues with addr 0..9 and distinct selects -> out_valid high for exactly 10 consecutive cycles starting 8 cycles after the first issue, addresses in order, with no gap or duplicate.
4. mode=3'b001 issue, then mode=3'b110 with in_valid=1 one cycle later -> err=2'b10; the second transaction exits at latency 8, not 5. After busy falls, a new 3'b110 issue exits at latency 5.
5. NUM_BF=3 (L=6, SEL_W=3): lane 0 sel=7 with in_valid=1 -> lane 0 = 0, err[0]=1; other lanes route correctly.
6. Assert rst 3 cycles into a mode=3'b001 burst -> outputs and busy drop to 0 immediately. No out_valid occurs in the following 10 cycles.
